// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   PAT_W_DEF    : default pattern length
//   PAT_INIT_DEF : default pattern loaded by reset (MSB is the first bit seen)
//   action_e     : per-cycle action chosen by the top-level priority logic
//   state_width  : width of the matched-prefix counter for a given pattern length
package seq_det_pkg;

  localparam int PAT_W_DEF = 5;
  localparam logic [PAT_W_DEF-1:0] PAT_INIT_DEF = 5'b10010;

  typedef enum logic [1:0] {
    ACT_HOLD,  // no qualified bit: state holds, pulse drops
    ACT_STEP,  // qualified bit: advance or fall back
    ACT_LOAD   // new pattern: restart the search
  } action_e;

  // Matched-prefix length ranges over 0..pat_w, so it needs clog2(pat_w+1) bits.
  function automatic int state_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-state logic for the pattern detector.
//   s       : current matched-prefix length (0..PAT_W-1)
//   a       : incoming serial bit
//   pat     : pattern, MSB first
//   overlap : 1 = resume from the pattern's longest border after a match
//   s_next  : matched-prefix length after consuming a
//   hit     : a completes the pattern
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  localparam int SW = state_width(PAT_W)
) (
  input  logic [SW-1:0]    s,
  input  logic             a,
  input  logic [PAT_W-1:0] pat,
  input  logic             overlap,
  output logic [SW-1:0]    s_next,
  output logic             hit
);

  // Candidate window right-aligned: w[0] is the new bit, w[m] is the bit seen
  // m positions earlier. The s earlier bits are by definition the top s bits
  // of the pattern, so they are recovered by shifting the pattern down.
  logic [PAT_W-1:0] w;
  logic             ok;
  logic             ok_b;
  int               fallback;
  int               border;

  // Longest k <= s+1 whose last k window bits equal the top k pattern bits.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    w        = ((pat >> (PAT_W - int'(s))) << 1) | PAT_W'(a);
    ok       = 1'b0;
    fallback = 0;
    for (int k = 1; k <= PAT_W; k++) begin
      ok = (k <= int'(s) + 1);
      for (int i = 0; i < k; i++) begin
        if (w[i] != pat[PAT_W-k+i]) ok = 1'b0;
      end
      if (ok) fallback = k;
    end
  end

  // Longest proper border of the pattern: where an overlapping search resumes.
  always_comb begin
    ok_b   = 1'b0;
    border = 0;
    for (int k = 1; k < PAT_W; k++) begin
      ok_b = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pat[i] != pat[PAT_W-k+i]) ok_b = 1'b0;
      end
      if (ok_b) border = k;
    end
  end

  always_comb begin
    hit    = (int'(s) == PAT_W - 1) && (a == pat[0]);
    s_next = SW'(fallback);
    if (hit) s_next = overlap ? SW'(border) : '0;
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with runtime-loadable pattern.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   a, en     : serial bit and its valid qualifier
//   overlap   : 1 = overlapping detection, 0 = restart from zero after a match
//   pat_load  : load pat_in (highest priority; a/en ignored that cycle)
//   pat_in    : new pattern, MSB is the first expected bit
//   cnt_clr   : synchronous clear of match_cnt (wins over a coincident match)
//   z         : registered one-cycle match pulse
//   cstate    : current matched-prefix length
//   match_cnt : saturating match count
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W    = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_INIT_DEF,
  parameter int               CNT_W    = 8,
  localparam int SW = state_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             en,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic [SW-1:0]    cstate,
  output logic [CNT_W-1:0] match_cnt
);

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] pat_d;
  logic [SW-1:0]    s_d;
  logic [SW-1:0]    s_next;
  logic             hit;
  logic             z_d;
  logic [CNT_W-1:0] cnt_d;
  action_e          act;

  seq_det_next #(.PAT_W(PAT_W)) u_next (
    .s       (cstate),
    .a       (a),
    .pat     (pat),
    .overlap (overlap),
    .s_next  (s_next),
    .hit     (hit)
  );

  always_comb begin
    act = ACT_HOLD;
    if (pat_load)  act = ACT_LOAD;
    else if (en)   act = ACT_STEP;

    pat_d = pat;
    s_d   = cstate;
    z_d   = 1'b0;
    cnt_d = match_cnt;

    case (act)
      ACT_LOAD: begin
        pat_d = pat_in;
        s_d   = '0;
      end
      ACT_STEP: begin
        s_d = s_next;
        z_d = hit;
        if (hit && !(&match_cnt)) cnt_d = match_cnt + CNT_W'(1);
      end
      default: ;
    endcase

    // Clear overrides any increment but leaves the pulse alone.
    if (cnt_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat       <= PAT_INIT;
      cstate    <= '0;
      z         <= 1'b0;
      match_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pat       <= pat_d;
      cstate    <= s_d;
      z         <= z_d;
      match_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param: default 5-bit pattern
// instance plus a 2-bit pattern / 2-bit counter instance for saturation.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic       en;
  logic       overlap;
  logic       pat_load;
  logic [4:0] pat_in;
  logic       cnt_clr;
  logic       z;
  logic [2:0] cstate;
  logic [7:0] match_cnt;

  logic       pat_load2 = 1'b0;
  logic [1:0] pat_in2   = 2'b00;
  logic       z2;
  logic [1:0] cstate2;
  logic [1:0] cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .en        (en),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .cnt_clr   (cnt_clr),
    .z         (z),
    .cstate    (cstate),
    .match_cnt (match_cnt)
  );

  seq_detect_param #(.PAT_W(2), .PAT_INIT(2'b11), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .en        (en),
    .overlap   (overlap),
    .pat_load  (pat_load2),
    .pat_in    (pat_in2),
    .cnt_clr   (cnt_clr),
    .z         (z2),
    .cstate    (cstate2),
    .match_cnt (cnt2)
  );

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; a = 1'b0; en = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    #2;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; a = 1'b0; en = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    #2;
    total++; if (z !== 1'b0)         $display("FAIL rst_z got=%b exp=0", z);         else passed++;
    total++; if (cstate !== 3'd0)    $display("FAIL rst_cstate got=%0d exp=0", cstate); else passed++;
    total++; if (match_cnt !== 8'd0) $display("FAIL rst_cnt got=%0d exp=0", match_cnt); else passed++;
    total++; if (z2 !== 1'b0)        $display("FAIL rst_z2 got=%b exp=0", z2);       else passed++;
    total++; if (cstate2 !== 2'd0)   $display("FAIL rst_cstate2 got=%0d exp=0", cstate2); else passed++;
    total++; if (cnt2 !== 2'd0)      $display("FAIL rst_cnt2 got=%0d exp=0", cnt2);  else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_overlap;
    logic [7:0] bits;
    logic [7:0] zexp;
    logic [2:0] cs [8];
    bits = 8'b10010010;
    zexp = 8'b00001001;
    cs   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4, 3'd2};
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = bits[7-i]; en = 1'b1;
      tick();
      total++; if (z !== zexp[7-i]) $display("FAIL ov_z bit%0d got=%b exp=%b", i+1, z, zexp[7-i]); else passed++;
      total++; if (cstate !== cs[i]) $display("FAIL ov_cstate bit%0d got=%0d exp=%0d", i+1, cstate, cs[i]); else passed++;
    end
    en = 1'b0;
    total++; if (match_cnt !== 8'd2) $display("FAIL ov_cnt got=%0d exp=2", match_cnt); else passed++;
  endtask

  task automatic test_non_overlap;
    logic [7:0] bits;
    logic [7:0] zexp;
    logic [2:0] cs [8];
    bits = 8'b10010010;
    zexp = 8'b00001000;
    cs   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd1, 3'd2};
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = bits[7-i]; en = 1'b1;
      tick();
      total++; if (z !== zexp[7-i]) $display("FAIL nov_z bit%0d got=%b exp=%b", i+1, z, zexp[7-i]); else passed++;
      total++; if (cstate !== cs[i]) $display("FAIL nov_cstate bit%0d got=%0d exp=%0d", i+1, cstate, cs[i]); else passed++;
    end
    en = 1'b0;
    total++; if (match_cnt !== 8'd1) $display("FAIL nov_cnt got=%0d exp=1", match_cnt); else passed++;
  endtask

  task automatic test_en_gap;
    logic [2:0] gap_a;
    gap_a = 3'b101;
    do_reset();
    overlap = 1'b1;
    en = 1'b1;
    a = 1'b1; tick();
    a = 1'b0; tick();
    a = 1'b0; tick();
    total++; if (cstate !== 3'd3) $display("FAIL gap_pre got=%0d exp=3", cstate); else passed++;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = gap_a[i];
      tick();
      total++; if (cstate !== 3'd3) $display("FAIL gap_hold%0d got=%0d exp=3", i, cstate); else passed++;
      total++; if (z !== 1'b0)      $display("FAIL gap_z%0d got=%b exp=0", i, z); else passed++;
    end
    en = 1'b1;
    a = 1'b1; tick();
    total++; if (cstate !== 3'd4) $display("FAIL gap_bit4 got=%0d exp=4", cstate); else passed++;
    a = 1'b0; tick();
    total++; if (z !== 1'b1)         $display("FAIL gap_match_z got=%b exp=1", z); else passed++;
    total++; if (cstate !== 3'd2)    $display("FAIL gap_match_cs got=%0d exp=2", cstate); else passed++;
    total++; if (match_cnt !== 8'd1) $display("FAIL gap_cnt got=%0d exp=1", match_cnt); else passed++;
    en = 1'b0; tick();
    total++; if (z !== 1'b0) $display("FAIL gap_z_drop got=%b exp=0", z); else passed++;
  endtask

  task automatic test_load;
    logic [7:0] bits;
    logic [7:0] zexp;
    logic [2:0] cs [8];
    bits = 8'b11011011;
    zexp = 8'b00001001;
    cs   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4, 3'd2};
    do_reset();
    overlap = 1'b1;
    en = 1'b1;
    a = 1'b1; tick();
    a = 1'b0; tick();
    a = 1'b0; tick();
    total++; if (cstate !== 3'd3) $display("FAIL ld_pre got=%0d exp=3", cstate); else passed++;
    pat_load = 1'b1; pat_in = 5'b11011; a = 1'b1;
    tick();
    pat_load = 1'b0;
    total++; if (cstate !== 3'd0)    $display("FAIL ld_cstate got=%0d exp=0", cstate); else passed++;
    total++; if (z !== 1'b0)         $display("FAIL ld_z got=%b exp=0", z); else passed++;
    total++; if (match_cnt !== 8'd0) $display("FAIL ld_cnt_kept got=%0d exp=0", match_cnt); else passed++;
    for (int i = 0; i < 8; i++) begin
      a = bits[7-i];
      tick();
      total++; if (z !== zexp[7-i]) $display("FAIL ld_z bit%0d got=%b exp=%b", i+1, z, zexp[7-i]); else passed++;
      total++; if (cstate !== cs[i]) $display("FAIL ld_cstate bit%0d got=%0d exp=%0d", i+1, cstate, cs[i]); else passed++;
    end
    en = 1'b0;
    total++; if (match_cnt !== 8'd2) $display("FAIL ld_cnt got=%0d exp=2", match_cnt); else passed++;
  endtask

  task automatic test_saturate;
    logic [5:0] zexp;
    logic [1:0] cexp [6];
    zexp = 6'b011111;
    cexp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 1'b1; en = 1'b1;
      tick();
      total++; if (z2 !== zexp[5-i])  $display("FAIL sat_z bit%0d got=%b exp=%b", i+1, z2, zexp[5-i]); else passed++;
      total++; if (cnt2 !== cexp[i])  $display("FAIL sat_cnt bit%0d got=%0d exp=%0d", i+1, cnt2, cexp[i]); else passed++;
      total++; if (cstate2 !== 2'd1)  $display("FAIL sat_cstate bit%0d got=%0d exp=1", i+1, cstate2); else passed++;
    end
    en = 1'b0;
  endtask

  task automatic test_clr_and_reset;
    logic [4:0] pat_bits;
    pat_bits = 5'b10010;
    do_reset();
    overlap = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = pat_bits[4-i]; tick();
    end
    total++; if (z !== 1'b1 || match_cnt !== 8'd1)
      $display("FAIL clr_first z=%b cnt=%0d exp z=1 cnt=1", z, match_cnt); else passed++;
    a = 1'b0; tick();
    a = 1'b1; tick();
    a = 1'b0; cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    total++; if (z !== 1'b1)         $display("FAIL clr_z got=%b exp=1", z); else passed++;
    total++; if (match_cnt !== 8'd0) $display("FAIL clr_cnt got=%0d exp=0", match_cnt); else passed++;
    a = 1'b0; tick();
    a = 1'b1; tick();
    a = 1'b0; tick();
    total++; if (z !== 1'b1 || match_cnt !== 8'd1 || cstate !== 3'd2)
      $display("FAIL clr_rematch z=%b cnt=%0d cs=%0d exp z=1 cnt=1 cs=2", z, match_cnt, cstate); else passed++;
    // Asynchronous reset between edges with a 2-bit prefix held.
    rst = 1'b1;
    #2;
    total++; if (z !== 1'b0)         $display("FAIL arst_z got=%b exp=0", z); else passed++;
    total++; if (cstate !== 3'd0)    $display("FAIL arst_cstate got=%0d exp=0", cstate); else passed++;
    total++; if (match_cnt !== 8'd0) $display("FAIL arst_cnt got=%0d exp=0", match_cnt); else passed++;
    rst = 1'b0;
    a = 1'b0; tick();
    total++; if (cstate !== 3'd0 || z !== 1'b0)
      $display("FAIL arst_discard cs=%0d z=%b exp cs=0 z=0", cstate, z); else passed++;
    for (int i = 0; i < 5; i++) begin
      a = pat_bits[4-i]; tick();
    end
    total++; if (z !== 1'b1 || match_cnt !== 8'd1)
      $display("FAIL arst_pat z=%b cnt=%0d exp z=1 cnt=1", z, match_cnt); else passed++;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_en_gap();
    test_load();
    test_saturate();
    test_clr_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
